// File: rtl/regfile_write_decode.sv
// Write side of the 32 x N register file: 5-bit destination decode into one-hot
// write enables, 31 enabled storage registers, and a hard-wired zero register 31.

module regfile_dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  assign y = {7'b0, en} << sel;
endmodule

module regfile_write_decode #(
  parameter int N    = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWrite,
  input  logic [4:0]      WriteRegister,
  input  logic [N-1:0]    WriteData,
  output logic [N-1:0]    regs [NREG-1:0],
  output logic [NREG-1:0] wr_onehot
);

  // No handshake: write-back presents RegWrite/WriteRegister/WriteData stable
  // around the rising edge and owns all sequencing; there is no stall path.

  logic [3:0]      bank_en;
  logic [NREG-1:0] full_onehot;

  // 2:4 bank select gated by RegWrite, each bank a 3:8 decoder on the low bits.
  assign bank_en = {4{RegWrite}} & (4'b0001 << WriteRegister[4:3]);

  for (genvar b = 0; b < 4; b++) begin : g_bank
    regfile_dec3to8 u_dec (
      .en  (bank_en[b]),
      .sel (WriteRegister[2:0]),
      .y   (full_onehot[b*8 +: 8])
    );
  end

  // Register 31 is XZR: its enable is masked so a write to it is dropped.
  assign wr_onehot = full_onehot & {1'b0, {(NREG-1){1'b1}}};

  for (genvar k = 0; k < NREG-1; k++) begin : g_reg
    logic [N-1:0] q;

    always_ff @(posedge clk) begin
      if (reset)
        q <= '0;
      else if (wr_onehot[k])
        q <= WriteData;
    end

    assign regs[k] = q;
  end

  assign regs[NREG-1] = '0;

endmodule

// File: tb/tb_regfile_write_decode.sv
// Directed bench for regfile_write_decode: reset, sweep, zero register,
// disabled writes, reset/write collision and write latency/overwrite.

module tb_regfile_write_decode;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [63:0] regs [31:0];
  logic [31:0] wr_onehot;

  int total = 0;
  int bad   = 0;

  logic [63:0] model [32];
  logic [63:0] exp_q [$];

  regfile_write_decode #(.N(64), .NREG(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regs          (regs),
    .wr_onehot     (wr_onehot)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge and settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [63:0] wd);
    reset         = rst;
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_x%0d", tag, i), regs[i], model[i]);
  endtask

  initial begin
    logic [63:0] v;
    for (int i = 0; i < 32; i++) model[i] = '0;

    drive(1'b1, 1'b0, 5'd0, 64'd0);
    cyc();
    check_all("por");

    // preload X5, then a one-edge reset clears it
    drive(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_00000005);
    chk("pre_onehot5", {32'd0, wr_onehot}, 64'h20);
    cyc();
    chk("preload_x5", regs[5], 64'hDEADBEEF_00000005);
    drive(1'b1, 1'b0, 5'd5, 64'd0);
    chk("rst_onehot_idle", {32'd0, wr_onehot}, 64'd0);
    cyc();
    check_all("reset");

    // full sweep, back-to-back writes to different registers
    for (int k = 0; k < 31; k++) begin
      v = (64'(k) << 32) | ~64'(k);
      drive(1'b0, 1'b1, 5'(k), v);
      chk($sformatf("sweep_onehot%0d", k), {32'd0, wr_onehot}, 64'd1 << k);
      model[k] = v;
      exp_q.push_back(v);
      cyc();
    end
    drive(1'b0, 1'b0, 5'd0, 64'd0);
    for (int k = 0; k < 31; k++)
      chk($sformatf("sweep_x%0d", k), regs[k], exp_q.pop_front());
    chk("sweep_x31", regs[31], 64'd0);

    // zero register ignores writes
    drive(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("xzr_onehot", {32'd0, wr_onehot}, 64'd0);
    cyc();
    check_all("xzr");

    // disabled write holds X7
    drive(1'b0, 1'b0, 5'd7, 64'h1234);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("dis_onehot_c%0d", c), {32'd0, wr_onehot}, 64'd0);
      cyc();
    end
    chk("dis_x7", regs[7], model[7]);

    // reset wins over a simultaneous write
    drive(1'b1, 1'b1, 5'd3, 64'hAAAA);
    chk("coll_onehot", {32'd0, wr_onehot}, 64'h8);
    cyc();
    for (int i = 0; i < 32; i++) model[i] = '0;
    chk("coll_x3", regs[3], 64'd0);
    check_all("coll");

    // latency and overwrite on X9; read of X9 during the second write is old
    drive(1'b0, 1'b1, 5'd9, 64'h11);
    chk("lat_pre", regs[9], 64'd0);
    cyc();
    drive(1'b0, 1'b1, 5'd9, 64'h22);
    chk("lat_t1_old", regs[9], 64'h11);
    cyc();
    drive(1'b0, 1'b0, 5'd9, 64'h33);
    chk("lat_t2_new", regs[9], 64'h22);
    cyc();
    chk("lat_t3_hold", regs[9], 64'h22);

    // mid-stream reset: earlier write stands until the reset edge
    drive(1'b0, 1'b1, 5'd12, 64'h0BAD_F00D);
    cyc();
    drive(1'b1, 1'b0, 5'd12, 64'd0);
    chk("mid_before_rst", regs[12], 64'h0BAD_F00D);
    cyc();
    chk("mid_after_rst", regs[12], 64'd0);
    chk("mid_after_rst_x9", regs[9], 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
